fp_ex_scheduler: RTL and testbench
==================================

# fp_ex_scheduler

Pipeline-control block for the FP core's ID/EX boundary. It sequences multi-cycle FALU operations (FDIV, FSQRT) by holding the ID/EX register and upstream stages while the operation occupies EX. It also detects load-use hazards between the instruction in EX and the one in ID, and inserts a bubble for them. It drives the enable and bubble-select of the ID/EX pipeline register and the hold of IF/ID/PC, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- DIV_LAT, 8, total EX-occupancy cycles for FDIV; legal range is ≥2.
- SQRT_LAT, 12, total EX-occupancy cycles for FSQRT; legal range is ≥2.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  reset, synchronous and active-low (rst==0 sampled at a clk rising edge resets).
- ex_valid  in  1  ID/EX output holds a real instruction.
- ex_falu_opcode  in  5  FALU opcode of the instruction in EX.
- ex_wb_sel  in  1  1 = EX instruction is a load (writeback from memory).
- ex_wb_int_en  in  1  EX instruction writes the integer register file.
- ex_wb_fp_en  in  1  EX instruction writes the FP register file.
- ex_rd_addr  in  5  destination register of the EX instruction.
- id_valid  in  1  ID holds a real instruction.
- id_rs1_addr, id_rs2_addr  in  5 each  source addresses of the ID instruction.
- id_use_int_rs1, id_use_int_rs2, id_use_fp_rs1, id_use_fp_rs2  in  1 each  the ID instruction reads that source from that file.
- if_id_hold  out  1  freeze PC and IF/ID.
- id_ex_en  out  1  ID/EX register load enable; 0 means hold.
- id_ex_bubble  out  1  when id_ex_en=1, load zeroed control fields (NOP) instead of the ID values.
- falu_busy  out  1  a multi-cycle operation is in progress (state BUSY).
- falu_done  out  1  final cycle of a multi-cycle operation; the FALU result is valid.
- stall_cycles  out  16  count of cycles with if_id_hold=1, saturating.

## Operation
- Multi-cycle op detection: `ex_multi = ex_valid & (ex_falu_opcode==FALU_FDIV | ex_falu_opcode==FALU_FSQRT)`. The latency `lat` is DIV_LAT for FDIV and SQRT_LAT for FSQRT.
- State machine, IDLE:
  - If ex_multi: load cnt = lat−2, go to BUSY, and assert if_id_hold=1 and id_ex_en=0 in this entry cycle.
- State machine, BUSY:
  - While cnt≠0: decrement cnt; if_id_hold=1, id_ex_en=0.
  - When cnt==0: falu_done=1, if_id_hold=0, id_ex_en=1, then return to IDLE. The pipeline advances this cycle.
- The multi-cycle op is accepted once per occupancy. In the cycle after the done cycle the state is IDLE and EX holds the next instruction. A back-to-back FDIV therefore starts a new occupancy immediately.
- Load-use hazard, evaluated only in IDLE when ex_multi=0:
  - `lu = id_valid & ex_valid & ex_wb_sel & ((ex_wb_int_en & ex_rd_addr≠0 & ((id_use_int_rs1 & id_rs1_addr==ex_rd_addr) | (id_use_int_rs2 & id_rs2_addr==ex_rd_addr))) | (ex_wb_fp_en & ((id_use_fp_rs1 & id_rs1_addr==ex_rd_addr) | (id_use_fp_rs2 & id_rs2_addr==ex_rd_addr))))`.
  - On lu: if_id_hold=1, id_ex_en=1, id_ex_bubble=1 for exactly one cycle. The next cycle EX holds the bubble, so lu clears.
- Priority: the multi-cycle stall overrides load-use. id_ex_bubble=0 whenever id_ex_en=0.
- Integer x0 never causes a hazard. FP f0 is an ordinary register.
- Default with no hazard and IDLE: if_id_hold=0, id_ex_en=1, id_ex_bubble=0.
- stall_cycles increments by 1 on every cycle with if_id_hold=1 and holds at 16'hFFFF.

## Timing
- Hazard outputs are combinational from the current state and inputs; there is no added latency.
- Registered elements are the state, cnt and stall_cycles.
- A multi-cycle op with latency L holds the pipeline for L−1 cycles. The L-th cycle is the done cycle.
- Reset (rst==0 at an edge) sets state=IDLE, cnt=0, stall_cycles=0.
- While rst==0, outputs are forced to: if_id_hold=0, id_ex_en=1, id_ex_bubble=1, falu_busy=0, falu_done=0. This flushes a NOP into ID/EX.
- Reset mid-BUSY abandons the operation: no falu_done is produced, and there is an IDLE start on the first cycle after reset.
- If ex_valid drops while in BUSY, the operation still completes. ID/EX is held, so this can only happen through a testbench fault; no requirement is placed on that case.

## Structure
- Shared package `fp_pkg` holds the FALU opcode constants, including FALU_FDIV=5'd3 and FALU_FSQRT=5'd4, and the state enum (IDLE, BUSY).
- Counter width is $clog2(max(DIV_LAT,SQRT_LAT)).
- One natural sub-module: `hazard_detect`, a combinational load-use comparator producing `lu`.
- The FSM, counter and stall counter stay in the top level.

## Test plan
- Reset: hold rst=0 for 3 cycles → id_ex_bubble=1, id_ex_en=1, if_id_hold=0, stall_cycles=0. After release, IDLE outputs show no hazard.
- FDIV, DIV_LAT=8: ex_valid=1, ex_falu_opcode=3 → if_id_hold=1 for 7 cycles, falu_done=1 on cycle 8 with id_ex_en=1, stall_cycles=7.
- Two back-to-back FSQRT, SQRT_LAT=12 → two 11-cycle holds separated by a single done cycle; stall_cycles=22.
- Integer load-use: EX is a load with int rd=5 and ID reads int rs2=5 → one cycle of if_id_hold=1 with id_ex_bubble=1. The same case with rd=0 → no stall.
- FP load to f0 with the ID instruction reading fp rs1=0 → one bubble. A load in EX that writes int rd=7 while ID reads fp rs1=7 → no stall.
- Reset mid-op: assert rst=0 at BUSY cnt=3 → next cycle IDLE, no falu_done; stall_cycles saturation checked by forcing a preload to 16'hFFFE plus 3 stall cycles → reads 16'hFFFF.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP-core definitions: FALU opcodes, scheduler state encoding and
// a small compile-time helper.
package fp_pkg;

    localparam logic [4:0] FALU_FADD  = 5'd0;
    localparam logic [4:0] FALU_FSUB  = 5'd1;
    localparam logic [4:0] FALU_FMUL  = 5'd2;
    localparam logic [4:0] FALU_FDIV  = 5'd3;
    localparam logic [4:0] FALU_FSQRT = 5'd4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sched_state_t;

    function automatic int lat_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator between the load in EX and the sources read in ID.
// Integer x0 is hardwired zero and never conflicts; FP f0 is a normal register.
module hazard_detect
    import fp_pkg::*;
(
    input  logic       i_id_valid,
    input  logic       i_ex_valid,
    input  logic       i_ex_wb_sel,
    input  logic       i_ex_wb_int_en,
    input  logic       i_ex_wb_fp_en,
    input  logic [4:0] i_ex_rd_addr,
    input  logic [4:0] i_id_rs1_addr,
    input  logic [4:0] i_id_rs2_addr,
    input  logic       i_id_use_int_rs1,
    input  logic       i_id_use_int_rs2,
    input  logic       i_id_use_fp_rs1,
    input  logic       i_id_use_fp_rs2,
    output logic       o_lu
);

    logic w_rs1_match;
    logic w_rs2_match;
    logic w_int_hit;
    logic w_fp_hit;

    assign w_rs1_match = (i_id_rs1_addr == i_ex_rd_addr);
    assign w_rs2_match = (i_id_rs2_addr == i_ex_rd_addr);

    assign w_int_hit = i_ex_wb_int_en & (i_ex_rd_addr != 5'd0) &
                       ((i_id_use_int_rs1 & w_rs1_match) |
                        (i_id_use_int_rs2 & w_rs2_match));

    assign w_fp_hit  = i_ex_wb_fp_en &
                       ((i_id_use_fp_rs1 & w_rs1_match) |
                        (i_id_use_fp_rs2 & w_rs2_match));

    assign o_lu = i_id_valid & i_ex_valid & i_ex_wb_sel & (w_int_hit | w_fp_hit);

endmodule

// File: rtl/fp_ex_scheduler.sv
// ID/EX pipeline control: sequences multi-cycle FDIV/FSQRT occupancy of EX,
// inserts load-use bubbles and counts stalled cycles.
module fp_ex_scheduler
    import fp_pkg::*;
#(
    parameter int DIV_LAT  = 8,
    parameter int SQRT_LAT = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_falu_opcode,
    input  logic        ex_wb_sel,
    input  logic        ex_wb_int_en,
    input  logic        ex_wb_fp_en,
    input  logic [4:0]  ex_rd_addr,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_use_int_rs1,
    input  logic        id_use_int_rs2,
    input  logic        id_use_fp_rs1,
    input  logic        id_use_fp_rs2,
    output logic        if_id_hold,
    output logic        id_ex_en,
    output logic        id_ex_bubble,
    output logic        falu_busy,
    output logic        falu_done,
    output logic [15:0] stall_cycles
);

    localparam int CNT_W = $clog2(lat_max(DIV_LAT, SQRT_LAT));

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_init;
    logic [15:0]      r_stall;

    logic w_is_div;
    logic w_is_sqrt;
    logic w_ex_multi;
    logic w_lu;
    logic w_hold;
    logic w_en;
    logic w_bubble;
    logic w_busy;
    logic w_done;

    assign w_is_div   = (ex_falu_opcode == FALU_FDIV);
    assign w_is_sqrt  = (ex_falu_opcode == FALU_FSQRT);
    assign w_ex_multi = ex_valid & (w_is_div | w_is_sqrt);
    // The entry cycle and the done cycle are both part of the occupancy, hence -2.
    assign w_cnt_init = w_is_div ? CNT_W'(DIV_LAT - 2) : CNT_W'(SQRT_LAT - 2);

    hazard_detect u_hazard_detect (
        .i_id_valid       (id_valid),
        .i_ex_valid       (ex_valid),
        .i_ex_wb_sel      (ex_wb_sel),
        .i_ex_wb_int_en   (ex_wb_int_en),
        .i_ex_wb_fp_en    (ex_wb_fp_en),
        .i_ex_rd_addr     (ex_rd_addr),
        .i_id_rs1_addr    (id_rs1_addr),
        .i_id_rs2_addr    (id_rs2_addr),
        .i_id_use_int_rs1 (id_use_int_rs1),
        .i_id_use_int_rs2 (id_use_int_rs2),
        .i_id_use_fp_rs1  (id_use_fp_rs1),
        .i_id_use_fp_rs2  (id_use_fp_rs2),
        .o_lu             (w_lu)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hold      = 1'b0;
        w_en        = 1'b1;
        w_bubble    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_ex_multi) begin
                    w_hold      = 1'b1;
                    w_en        = 1'b0;
                    w_cnt_nxt   = w_cnt_init;
                    w_state_nxt = BUSY;
                end else if (w_lu) begin
                    w_hold   = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            BUSY: begin
                w_busy = 1'b1;
                if (r_cnt != '0) begin
                    w_hold    = 1'b1;
                    w_en      = 1'b0;
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Reset flushes a NOP into ID/EX regardless of the current state.
        if (!rst) begin
            w_hold   = 1'b0;
            w_en     = 1'b1;
            w_bubble = 1'b1;
            w_busy   = 1'b0;
            w_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_hold && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign if_id_hold   = w_hold;
    assign id_ex_en     = w_en;
    assign id_ex_bubble = w_bubble;
    assign falu_busy    = w_busy;
    assign falu_done    = w_done;
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_fp_ex_scheduler.sv
// Scoreboard bench for fp_ex_scheduler: the driver queues hand-derived
// expected outputs per cycle, a negedge monitor pops and compares them.
module tb_fp_ex_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        exValid;
    logic [4:0]  exFaluOpcode;
    logic        exWbSel;
    logic        exWbIntEn;
    logic        exWbFpEn;
    logic [4:0]  exRdAddr;
    logic        idValid;
    logic [4:0]  idRs1Addr;
    logic [4:0]  idRs2Addr;
    logic        idUseIntRs1;
    logic        idUseIntRs2;
    logic        idUseFpRs1;
    logic        idUseFpRs2;
    logic        ifIdHold;
    logic        idExEn;
    logic        idExBubble;
    logic        faluBusy;
    logic        faluDone;
    logic [15:0] stallCycles;

    typedef struct {
        string       tag;
        logic [4:0]  flags;
        logic [15:0] stall;
    } exp_t;

    exp_t        scoreQ[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] expStall = 16'd0;

    fp_ex_scheduler #(.DIV_LAT(8), .SQRT_LAT(12)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (exValid),
        .ex_falu_opcode (exFaluOpcode),
        .ex_wb_sel      (exWbSel),
        .ex_wb_int_en   (exWbIntEn),
        .ex_wb_fp_en    (exWbFpEn),
        .ex_rd_addr     (exRdAddr),
        .id_valid       (idValid),
        .id_rs1_addr    (idRs1Addr),
        .id_rs2_addr    (idRs2Addr),
        .id_use_int_rs1 (idUseIntRs1),
        .id_use_int_rs2 (idUseIntRs2),
        .id_use_fp_rs1  (idUseFpRs1),
        .id_use_fp_rs2  (idUseFpRs2),
        .if_id_hold     (ifIdHold),
        .id_ex_en       (idExEn),
        .id_ex_bubble   (idExBubble),
        .falu_busy      (faluBusy),
        .falu_done      (faluDone),
        .stall_cycles   (stallCycles)
    );

    always #5 clk = ~clk;

    // Monitor: flags are {hold, en, bubble, busy, done}.
    always @(negedge clk) begin
        if (scoreQ.size() > 0) begin
            exp_t       e;
            logic [4:0] act;
            e   = scoreQ.pop_front();
            act = {ifIdHold, idExEn, idExBubble, faluBusy, faluDone};
            checks++;
            if (act !== e.flags || stallCycles !== e.stall) begin
                errors++;
                $display("[TB] FAIL %s: got hold/en/bub/busy/done=%b stall=%h, expected %b stall=%h",
                         e.tag, act, stallCycles, e.flags, e.stall);
            end
        end
    end

    task automatic tick(input logic expHold);
        @(posedge clk);
        if (!rst) expStall = 16'd0;
        else if (expHold && expStall != 16'hFFFF) expStall = expStall + 16'd1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic hold, input logic en,
                               input logic bub, input logic busy, input logic done);
        exp_t e;
        e.tag   = tag;
        e.flags = {hold, en, bub, busy, done};
        e.stall = expStall;
        scoreQ.push_back(e);
        tick(hold);
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic wbSel,
                                 input logic intEn, input logic fpEn, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [3:0] uses);
        exValid      = v;
        exFaluOpcode = op;
        exWbSel      = wbSel;
        exWbIntEn    = intEn;
        exWbFpEn     = fpEn;
        exRdAddr     = rd;
        idValid      = 1'b1;
        idRs1Addr    = rs1;
        idRs2Addr    = rs2;
        {idUseIntRs1, idUseIntRs2, idUseFpRs1, idUseFpRs2} = uses;
    endtask

    task automatic clearStimulus();
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'b0000);
    endtask

    task automatic runMulti(input string tag, input int lat);
        for (int i = 0; i < lat - 1; i++) checkOutput(tag, 1'b1, 1'b0, 1'b0, (i > 0), 1'b0);
        checkOutput({tag, "_done"}, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b0;
        clearStimulus();
        tick(1'b0);
        checkOutput("reset_a", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("reset_b", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        checkOutput("idle_after_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // FDIV: 7 hold cycles then done; stall count shows 7 afterwards.
        applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 4'b0000);
        runMulti("fdiv", 8);
        clearStimulus();
        checkOutput("post_fdiv", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back FSQRT: 11 holds, done, 11 holds, done (stall 7+22).
        applyStimulus(1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 4'b0000);
        runMulti("fsqrt1", 12);
        runMulti("fsqrt2", 12);
        clearStimulus();
        checkOutput("post_fsqrt", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Integer load-use on rs2=5, then the bubble reaches EX.
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd5, 4'b0100);
        checkOutput("lu_int_rs2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        clearStimulus();
        checkOutput("lu_int_cleared", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd0, 4'b0100);
        checkOutput("lu_int_x0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 4'b0010);
        checkOutput("lu_fp_f0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 4'b0010);
        checkOutput("lu_int_rd_fp_src", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 4'b1000);
        checkOutput("no_lu_not_load", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // FDIV with a simultaneous load-use match: the multi-cycle stall wins.
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd6, 5'd6, 5'd0, 4'b1000);
        runMulti("fdiv_prio", 8);
        clearStimulus();
        checkOutput("post_prio", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset mid-op at cnt=3 (fifth occupancy cycle): no done afterwards.
        applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 4'b0000);
        for (int i = 0; i < 4; i++) checkOutput("fdiv_pre_rst", 1'b1, 1'b0, 1'b0, (i > 0), 1'b0);
        rst = 1'b0;
        checkOutput("rst_mid_busy", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        clearStimulus();
        checkOutput("after_rst_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("after_rst_nodone", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Saturation: a persistent load-use match holds every cycle.
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 4'b1000);
        for (int i = 0; i < 65534; i++) tick(1'b1);
        checkOutput("sat_fffe", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_ffff", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_hold", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        clearStimulus();
        checkOutput("sat_final", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        if (scoreQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", scoreQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
